// File: rtl/rmst_to_fifo_tile_2d.sv
// 2D tile loader: issues row-bounded bursts on an Avalon read master and unpacks XDW beats into DW words for a load FIFO.
// Optional macro RMST_TILE_LAST_EN adds load_fifo_last and row_done_cnt.
module rmst_to_fifo_tile_2d #(
    parameter int CW            = 16,
    parameter int DW            = 32,
    parameter int XAW           = 32,
    parameter int XDW           = 128,
    parameter int BLEN          = 8,
    parameter int RMST_FIFO_CAP = 128
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_start,
    input  logic [XAW-1:0] desc_base,
    input  logic [CW-1:0]  desc_row_len,
    input  logic [CW-1:0]  desc_rows,
    input  logic [XAW-1:0] desc_stride,
    output logic           load_busy,
    output logic           load_done,
    output logic           rmst_fixed_location,
    output logic [XAW-1:0] rmst_read_base,
    output logic [XAW-1:0] rmst_read_length,
    output logic           rmst_go,
    input  logic           rmst_done,
    output logic           rmst_user_read_buffer,
    input  logic [XDW-1:0] rmst_user_buffer_data,
    input  logic           rmst_user_data_available,
    output logic [DW-1:0]  rmst_load_data,
`ifdef RMST_TILE_LAST_EN
    output logic           load_fifo_last,
    output logic [CW-1:0]  row_done_cnt,
`endif
    output logic           load_fifo_push,
    input  logic           load_fifo_almost_full
);

    localparam int RATIO = XDW / DW;
    localparam int IW    = $clog2(RATIO);
    localparam int PW    = CW + 8;
    localparam logic [CW-1:0]  BLEN_W   = CW'(BLEN);
    localparam logic [XAW-1:0] BPW      = XAW'(DW / 8);
    localparam logic [PW-1:0]  CAP_W    = PW'(RMST_FIFO_CAP);
    localparam logic [IW-1:0]  IDX_LAST = IW'(RATIO - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FLUSH} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  row_len_q, row_len_d;
    logic [XAW-1:0] stride_q, stride_d;
    logic [XAW-1:0] addr_q, addr_d;
    logic [XAW-1:0] row_start_q, row_start_d;
    logic [CW-1:0]  words_left_q, words_left_d;
    logic [CW-1:0]  rows_left_q, rows_left_d;
    logic [PW-1:0]  issued_q, issued_d;
    logic [PW-1:0]  pushed_q, pushed_nx;
    logic [1:0]     guard_q, guard_d;
    logic           go_q, go_d;
    logic [XAW-1:0] read_base_q, read_base_d;
    logic [XAW-1:0] read_length_q, read_length_d;
    logic           done_q, done_d;

    logic [XDW-1:0] beat_q;
    logic           beat_valid_q;
    logic           pend_q;
    logic [IW-1:0]  idx_q;
    logic [CW-1:0]  col_q;

    logic [CW-1:0]  burst;
    logic [XAW-1:0] burst_bytes;
    logic           can_go, all_pushed, start_acc, busy;
    logic           push, pop, row_last, beat_last;

    assign busy        = (state_q != S_IDLE);
    assign start_acc   = (state_q == S_IDLE) && load_start;
    assign burst       = (words_left_q < BLEN_W) ? words_left_q : BLEN_W;
    assign burst_bytes = XAW'(burst) * BPW;
    assign can_go      = rmst_done && (guard_q == 2'd0) &&
                         ((issued_q - pushed_q + PW'(burst)) <= CAP_W);

    // Handshakes: rmst_user_read_buffer is a one-cycle pop strobe and the popped beat
    // is on rmst_user_buffer_data the following cycle; a word is transferred to the
    // FIFO in any cycle where load_fifo_push is high, which already includes !almost_full.
    assign row_last   = (col_q == row_len_q - CW'(1));
    assign beat_last  = (idx_q == IDX_LAST) || row_last;
    assign push       = beat_valid_q && !load_fifo_almost_full;
    assign pop        = busy && rmst_user_data_available && !pend_q &&
                        (!beat_valid_q || (push && beat_last));
    assign pushed_nx  = pushed_q + PW'(push);
    assign all_pushed = (pushed_nx == issued_q);

    always_comb begin
        state_d       = state_q;
        row_len_d     = row_len_q;
        stride_d      = stride_q;
        addr_d        = addr_q;
        row_start_d   = row_start_q;
        words_left_d  = words_left_q;
        rows_left_d   = rows_left_q;
        issued_d      = issued_q;
        guard_d       = (guard_q != 2'd0) ? guard_q - 2'd1 : 2'd0;
        go_d          = 1'b0;
        read_base_d   = read_base_q;
        read_length_d = read_length_q;
        done_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    row_len_d    = desc_row_len;
                    stride_d     = desc_stride;
                    addr_d       = desc_base;
                    row_start_d  = desc_base;
                    words_left_d = desc_row_len;
                    rows_left_d  = desc_rows;
                    issued_d     = '0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (can_go) begin
                    go_d          = 1'b1;
                    read_base_d   = addr_q;
                    read_length_d = burst_bytes;
                    issued_d      = issued_q + PW'(burst);
                    guard_d       = 2'd2;
                    // A burst never crosses a row; the row end jumps to the next row start.
                    if (burst == words_left_q) begin
                        rows_left_d  = rows_left_q - CW'(1);
                        addr_d       = row_start_q + stride_q;
                        row_start_d  = row_start_q + stride_q;
                        words_left_d = row_len_q;
                    end else begin
                        addr_d       = addr_q + burst_bytes;
                        words_left_d = words_left_q - burst;
                    end
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (guard_q == 2'd0) begin
                    if (rows_left_q == '0) begin
                        if (all_pushed) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_FLUSH;
                        end
                    end else if (rmst_done) begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_FLUSH: begin
                if (all_pushed) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            row_len_q     <= '0;
            stride_q      <= '0;
            addr_q        <= '0;
            row_start_q   <= '0;
            words_left_q  <= '0;
            rows_left_q   <= '0;
            issued_q      <= '0;
            guard_q       <= '0;
            go_q          <= 1'b0;
            read_base_q   <= '0;
            read_length_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_len_q     <= row_len_d;
            stride_q      <= stride_d;
            addr_q        <= addr_d;
            row_start_q   <= row_start_d;
            words_left_q  <= words_left_d;
            rows_left_q   <= rows_left_d;
            issued_q      <= issued_d;
            guard_q       <= guard_d;
            go_q          <= go_d;
            read_base_q   <= read_base_d;
            read_length_q <= read_length_d;
            done_q        <= done_d;
        end
    end

    // Unpacker: col_q tracks the row position so surplus words of a partial last beat are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q       <= '0;
            beat_valid_q <= 1'b0;
            pend_q       <= 1'b0;
            idx_q        <= '0;
            col_q        <= '0;
            pushed_q     <= '0;
        end else begin
            pend_q <= pop;
            if (pend_q) begin
                beat_q       <= rmst_user_buffer_data;
                beat_valid_q <= 1'b1;
                idx_q        <= '0;
            end else if (push) begin
                idx_q <= idx_q + IW'(1);
                if (beat_last) beat_valid_q <= 1'b0;
            end
            if (start_acc) begin
                col_q    <= '0;
                pushed_q <= '0;
            end else begin
                pushed_q <= pushed_nx;
                if (push) col_q <= row_last ? '0 : col_q + CW'(1);
            end
        end
    end

`ifdef RMST_TILE_LAST_EN
    logic [CW-1:0] row_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt_q <= '0;
        end else if (start_acc) begin
            row_cnt_q <= '0;
        end else if (push && row_last) begin
            row_cnt_q <= row_cnt_q + CW'(1);
        end
    end

    assign load_fifo_last = push && row_last;
    assign row_done_cnt   = row_cnt_q;
`endif

    assign load_busy             = busy;
    assign load_done             = done_q;
    assign rmst_fixed_location   = 1'b0;
    assign rmst_read_base        = read_base_q;
    assign rmst_read_length      = read_length_q;
    assign rmst_go               = go_q;
    assign rmst_user_read_buffer = pop;
    assign rmst_load_data        = beat_q[idx_q*DW +: DW];
    assign load_fifo_push        = push;

endmodule

// File: tb/tb_rmst_to_fifo_tile_2d.sv
// Bench for rmst_to_fifo_tile_2d: behavioural read-master/memory model, descriptor table, and word/burst scoreboards.
module tb_rmst_to_fifo_tile_2d;

    localparam int CW   = 16;
    localparam int DW   = 32;
    localparam int XAW  = 32;
    localparam int XDW  = 128;
    localparam int BLEN = 8;
    localparam int CAP  = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           load_start = 1'b0;
    logic [XAW-1:0] desc_base = '0;
    logic [CW-1:0]  desc_row_len = '0;
    logic [CW-1:0]  desc_rows = '0;
    logic [XAW-1:0] desc_stride = '0;
    logic           load_fifo_almost_full = 1'b0;
    logic           load_busy, load_done, rmst_fixed_location, rmst_go;
    logic [XAW-1:0] rmst_read_base, rmst_read_length;
    logic           rmst_done;
    logic           rmst_user_read_buffer;
    logic [XDW-1:0] rmst_user_buffer_data;
    logic           rmst_user_data_available;
    logic [DW-1:0]  rmst_load_data;
    logic           load_fifo_push;
`ifdef RMST_TILE_LAST_EN
    logic           load_fifo_last;
    logic [CW-1:0]  row_done_cnt;
    logic           exp_last_q[$];
`endif

    always #5 clk = ~clk;

    rmst_to_fifo_tile_2d #(
        .CW(CW), .DW(DW), .XAW(XAW), .XDW(XDW), .BLEN(BLEN), .RMST_FIFO_CAP(CAP)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .load_start               (load_start),
        .desc_base                (desc_base),
        .desc_row_len             (desc_row_len),
        .desc_rows                (desc_rows),
        .desc_stride              (desc_stride),
        .load_busy                (load_busy),
        .load_done                (load_done),
        .rmst_fixed_location      (rmst_fixed_location),
        .rmst_read_base           (rmst_read_base),
        .rmst_read_length         (rmst_read_length),
        .rmst_go                  (rmst_go),
        .rmst_done                (rmst_done),
        .rmst_user_read_buffer    (rmst_user_read_buffer),
        .rmst_user_buffer_data    (rmst_user_buffer_data),
        .rmst_user_data_available (rmst_user_data_available),
        .rmst_load_data           (rmst_load_data),
`ifdef RMST_TILE_LAST_EN
        .load_fifo_last           (load_fifo_last),
        .row_done_cnt             (row_done_cnt),
`endif
        .load_fifo_push           (load_fifo_push),
        .load_fifo_almost_full    (load_fifo_almost_full)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_push = 0;
    int n_go = 0;
    int snap2 = -1;
    int last_push_cyc = 0;
    int done_cyc = 0;
    logic done_seen = 1'b0;
    int af_mode = 0;

    logic [DW-1:0] exp_q[$];
    logic [63:0]   exp_go_q[$];
    logic [DW-1:0] e_word;
    logic [63:0]   e_go;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [XDW-1:0] make_beat(input logic [31:0] a);
        logic [XDW-1:0] b;
        b = '0;
        for (int j = 0; j < XDW / DW; j++) b[j*DW +: DW] = mem_word(a + 32'(4 * j));
        return b;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Read-master model: a burst lands in the beat buffer a few cycles after go; a pop
    // presents the head beat on the data bus the next cycle.
    logic           bfm_busy;
    int             bfm_cnt;
    logic [31:0]    bfm_addr, bfm_len;
    logic [XDW-1:0] bfm_q[$];

    always @(posedge clk) begin
        if (rst) begin
            bfm_q.delete();
            bfm_busy                 <= 1'b0;
            bfm_cnt                  <= 0;
            bfm_addr                 <= '0;
            bfm_len                  <= '0;
            rmst_done                <= 1'b1;
            rmst_user_data_available <= 1'b0;
            rmst_user_buffer_data    <= '0;
        end else begin
            if (rmst_user_read_buffer && bfm_q.size() != 0)
                rmst_user_buffer_data <= bfm_q.pop_front();
            if (rmst_go) begin
                bfm_busy  <= 1'b1;
                bfm_cnt   <= 3;
                bfm_addr  <= rmst_read_base;
                bfm_len   <= rmst_read_length;
                rmst_done <= 1'b0;
            end else if (bfm_busy) begin
                if (bfm_cnt == 0) begin
                    for (int k = 0; k < int'((bfm_len + 32'd15) / 32'd16); k++)
                        bfm_q.push_back(make_beat(bfm_addr + 32'(16 * k)));
                    bfm_busy  <= 1'b0;
                    rmst_done <= 1'b1;
                end else begin
                    bfm_cnt <= bfm_cnt - 1;
                end
            end
            rmst_user_data_available <= (bfm_q.size() != 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (af_mode)
                1:       load_fifo_almost_full = 1'b1;
                2:       load_fifo_almost_full = ~load_fifo_almost_full;
                default: load_fifo_almost_full = 1'b0;
            endcase
        end
    end

    // Monitor: every push and every go is checked against the expected queues.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (load_fifo_push) begin
                    n_push++;
                    last_push_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_push: got %0h expected no push", rmst_load_data);
                    end else begin
                        e_word = exp_q.pop_front();
                        chk("push_data", 128'(rmst_load_data), 128'(e_word));
`ifdef RMST_TILE_LAST_EN
                        if (exp_last_q.size() != 0)
                            chk("push_last", 128'(load_fifo_last), 128'(exp_last_q.pop_front()));
`endif
                    end
                end
                if (rmst_go) begin
                    n_go++;
                    if (n_go == 2) snap2 = n_push;
                    chk("go_when_done", 128'(rmst_done), 128'(1));
                    if (exp_go_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_go: got base %0h len %0h expected no go", rmst_read_base, rmst_read_length);
                    end else begin
                        e_go = exp_go_q.pop_front();
                        chk("go_base_len", 128'({rmst_read_base, rmst_read_length}), 128'(e_go));
                    end
                end
                if (load_done) begin
                    done_seen = 1'b1;
                    done_cyc  = cyc;
                end
            end
        end
    end

    task automatic start_load(input logic [31:0] base, input int len, input int rows,
                              input logic [31:0] stride, output int ngo);
        int b;
        ngo = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < len; c++) begin
                exp_q.push_back(mem_word(base + 32'(r) * stride + 32'(4 * c)));
`ifdef RMST_TILE_LAST_EN
                exp_last_q.push_back(c == len - 1);
`endif
            end
            for (int c = 0; c < len; c += BLEN) begin
                b = (len - c < BLEN) ? len - c : BLEN;
                exp_go_q.push_back({base + 32'(r) * stride + 32'(4 * c), 32'(b * 4)});
                ngo++;
            end
        end
        n_push    = 0;
        n_go      = 0;
        snap2     = -1;
        done_seen = 1'b0;
        @(posedge clk);
        #1;
        desc_base    = base;
        desc_row_len = CW'(len);
        desc_rows    = CW'(rows);
        desc_stride  = stride;
        load_start   = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 128'({load_busy, load_done}), 128'(2'b10));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            if (done_seen) break;
        end
        chk("done_seen", 128'(done_seen), 128'(1));
    endtask

    task automatic end_checks(input int len, input int rows, input int ngo);
        chk("push_count", 128'(n_push), 128'(len * rows));
        chk("go_count", 128'(n_go), 128'(ngo));
        chk("queues_drained", 128'({exp_q.size(), exp_go_q.size()}), 128'(0));
        chk("done_latency", 128'(done_cyc - last_push_cyc), 128'(1));
        chk("idle_after_done", 128'(load_busy), 128'(0));
    endtask

    task automatic run_load(input logic [31:0] base, input int len, input int rows,
                            input logic [31:0] stride, input int exp_gos);
        int ngo;
        start_load(base, len, rows, stride, ngo);
        chk("model_go_count", 128'(ngo), 128'(exp_gos));
        wait_done();
        end_checks(len, rows, ngo);
    endtask

    typedef struct {
        logic [31:0] base;
        int          len;
        int          rows;
        logic [31:0] stride;
        int          gos;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int ngo, rl, rr;
        logic [31:0] rb, rs;
        vecs[0] = '{32'h1000, 16, 1, 32'h0,   2};
        vecs[1] = '{32'h0000, 6,  3, 32'h100, 3};
        vecs[2] = '{32'h2000, 5,  2, 32'h40,  2};
        vecs[3] = '{32'h3000, 13, 2, 32'h80,  4};
        vecs[4] = '{32'h4000, 1,  4, 32'h10,  4};
        vecs[5] = '{32'h4800, 8,  2, 32'h20,  2};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 128'({load_busy, load_done, rmst_fixed_location, rmst_go,
            rmst_user_read_buffer, load_fifo_push, rmst_read_base, rmst_read_length,
            rmst_load_data}), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int v = 0; v < 6; v++)
            run_load(vecs[v].base, vecs[v].len, vecs[v].rows, vecs[v].stride, vecs[v].gos);

        for (int i = 0; i < 3; i++) begin
            rb = 32'($urandom_range(0, 255) * 16);
            rl = $urandom_range(1, 20);
            rr = $urandom_range(1, 3);
            rs = 32'(((rl + 3) / 4 + $urandom_range(0, 2)) * 16);
            start_load(rb, rl, rr, rs, ngo);
            wait_done();
            end_checks(rl, rr, ngo);
        end

        // Capacity limit: with the FIFO blocked only one burst fits in the read-master buffer.
        af_mode = 1;
        start_load(32'h8000, 32, 1, 32'h0, ngo);
        repeat (60) @(negedge clk);
        #1;
        chk("cap_one_go", 128'({n_go, n_push}), 128'({32'd1, 32'd0}));
        af_mode = 0;
        for (int i = 0; i < 500 && n_go < 2; i++) begin
            @(negedge clk);
            #1;
        end
        chk("cap_second_go_after_8", 128'(snap2), 128'(8));
        wait_done();
        end_checks(32, 1, ngo);

        // Backpressure every other cycle, with a stray load_start while busy.
        af_mode = 2;
        start_load(32'h5000, 16, 1, 32'h0, ngo);
        repeat (10) @(posedge clk);
        #1;
        desc_base    = 32'h9990;
        desc_row_len = 16'd3;
        desc_rows    = 16'd7;
        load_start   = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        wait_done();
        end_checks(16, 1, ngo);
        af_mode = 0;

        // Reset in the middle of a transfer, then a fresh descriptor.
        start_load(32'h6000, 16, 2, 32'h100, ngo);
        for (int i = 0; i < 500 && n_push < 3; i++) begin
            @(negedge clk);
            #1;
        end
        chk("pushes_before_reset", 128'(n_push >= 3), 128'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        exp_go_q.delete();
`ifdef RMST_TILE_LAST_EN
        exp_last_q.delete();
`endif
        @(negedge clk);
        chk("mid_reset_outputs", 128'({load_busy, load_done, rmst_fixed_location, rmst_go,
            rmst_user_read_buffer, load_fifo_push, rmst_read_base, rmst_read_length,
            rmst_load_data}), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_load(32'h7000, 10, 2, 32'h40, 4);

`ifdef RMST_TILE_LAST_EN
        run_load(32'hA000, 4, 2, 32'h20, 2);
        chk("row_done_cnt", 128'(row_done_cnt), 128'(2));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
